// File: rtl/alu_rs.sv
// ALU reservation station: age-matrix oldest-ready select with
// writeback snooping for operand wakeup.
package alu_rs_pkg;

    typedef struct packed {
        logic [5:0]  rob_tag;
        logic [3:0]  op;
        logic [31:0] imm;
        logic        rd_used;
        logic [5:0]  prd;
        logic        rs1_used;
        logic [5:0]  prs1;
        logic        rs1_rdy;
        logic        rs2_used;
        logic [5:0]  prs2;
        logic        rs2_rdy;
    } rs_entry_t;

    typedef struct packed {
        logic       valid;
        logic       rd_used;
        logic [5:0] prd;
    } wb_pkt_t;

endpackage

module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     disp_valid_i,
    output logic                     disp_ready_o,
    input  rs_entry_t                disp_entry_i,
    input  wb_pkt_t [NUM_WB-1:0]     wb_i,
    output logic                     issue_valid_o,
    output rs_entry_t                issue_entry_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] r1;
    logic [DEPTH-1:0] r2;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] sel;
    rs_entry_t        ents [DEPTH];
    logic [DEPTH-1:0] age  [DEPTH];

    logic [IW-1:0]    slot;
    logic [CW-1:0]    cnt;
    logic             any_sel;
    logic             disp_fire;
    rs_entry_t        pick;

    function automatic logic woke(input logic [5:0] p);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_i[k].valid && wb_i[k].rd_used && wb_i[k].prd == p) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        ready = '0;
        cnt   = '0;
        slot  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid[i]
                     && (!ents[i].rs1_used || r1[i])
                     && (!ents[i].rs2_used || r2[i]);
            cnt = cnt + CW'(valid[i]);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                slot = IW'(i);
            end
        end
    end

    // An entry wins only if no older entry is also ready.
    always_comb begin
        sel  = '0;
        pick = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && age[j][i]) begin
                    sel[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                pick = pick | ents[i];
            end
        end
    end

    assign any_sel       = |sel;
    assign issue_valid_o = any_sel && !flush_i;
    assign count_o       = cnt;
    assign disp_ready_o  = cnt < CW'(DEPTH);
    assign disp_fire     = disp_valid_i && disp_ready_o && !flush_i;

    always_comb begin
        issue_entry_o = pick;
        if (any_sel) begin
            issue_entry_o.rs1_rdy = 1'b1;
            issue_entry_o.rs2_rdy = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            r1    <= '0;
            r2    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age[i]  <= '0;
                ents[i] <= '0;
            end
        end else if (flush_i) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && woke(ents[i].prs1)) begin
                    r1[i] <= 1'b1;
                end
                if (valid[i] && woke(ents[i].prs2)) begin
                    r2[i] <= 1'b1;
                end
                if (issue_valid_o && sel[i]) begin
                    valid[i] <= 1'b0;
                end
            end
            // New entry is youngest: its row clears, its column marks live entries.
            if (disp_fire) begin
                valid[slot] <= 1'b1;
                ents[slot]  <= disp_entry_i;
                r1[slot]    <= disp_entry_i.rs1_rdy || woke(disp_entry_i.prs1);
                r2[slot]    <= disp_entry_i.rs2_rdy || woke(disp_entry_i.prs2);
                age[slot]   <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != int'(slot)) begin
                        age[j][slot] <= valid[j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: vector table plus issue scoreboard keyed on
// rob_tag and issue cycle.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int DEPTH  = 8;
    localparam int NUM_WB = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush_i;
    logic                   disp_valid_i;
    logic                   disp_ready_o;
    rs_entry_t              disp_entry_i;
    wb_pkt_t [NUM_WB-1:0]   wb_i;
    logic                   issue_valid_o;
    rs_entry_t              issue_entry_o;
    logic [$clog2(DEPTH):0] count_o;

    alu_rs #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .disp_valid_i  (disp_valid_i),
        .disp_ready_o  (disp_ready_o),
        .disp_entry_i  (disp_entry_i),
        .wb_i          (wb_i),
        .issue_valid_o (issue_valid_o),
        .issue_entry_o (issue_entry_o),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int tag;
        int cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int tag;
        bit u1, d1, u2, d2;
        int wsrc;
        int wbus;
        bit wrdu;
        bit issues;
        int exp_cnt;
    } vec_t;
    vec_t vt[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && issue_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue_tag", int'(issue_entry_o.rob_tag), -1);
            end else begin
                e = sb.pop_front();
                chk("issue_tag", int'(issue_entry_o.rob_tag), e.tag);
                chk("issue_cycle", cyc, e.cyc);
                chk("issue_rdy",
                    int'({issue_entry_o.rs1_rdy, issue_entry_o.rs2_rdy}), 3);
            end
        end
    end

    function automatic rs_entry_t mk(input int tag,
                                     input bit u1, input bit d1, input int p1,
                                     input bit u2, input bit d2, input int p2);
        rs_entry_t e;
        e          = '0;
        e.rob_tag  = 6'(tag);
        e.rs1_used = u1;
        e.rs1_rdy  = d1;
        e.prs1     = 6'(p1);
        e.rs2_used = u2;
        e.rs2_rdy  = d2;
        e.prs2     = 6'(p2);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        disp_valid_i = 1'b0;
        disp_entry_i = '0;
        flush_i      = 1'b0;
        wb_i         = '0;
    endtask

    task automatic disp(input rs_entry_t e);
        disp_valid_i = 1'b1;
        disp_entry_i = e;
    endtask

    task automatic wake(input int bus, input int prd, input bit rdu);
        wb_i[bus].valid   = 1'b1;
        wb_i[bus].rd_used = rdu;
        wb_i[bus].prd     = 6'(prd);
    endtask

    task automatic push(input int tag, input int at);
        exp_t e;
        e.tag = tag;
        e.cyc = at;
        sb.push_back(e);
    endtask

    initial begin
        vt[0] = '{5, 1, 1, 1, 1, 0, 0, 0, 1, 0};
        vt[1] = '{6, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        vt[2] = '{3, 1, 0, 1, 1, 1, 1, 1, 1, 0};
        vt[3] = '{4, 1, 0, 1, 1, 1, 1, 0, 0, 1};
        vt[4] = '{7, 1, 1, 1, 0, 2, 0, 1, 1, 0};
        vt[5] = '{8, 1, 0, 1, 0, 1, 0, 1, 0, 1};

        // reset with a dispatch request held high
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        wb_i         = '0;
        disp_valid_i = 1'b1;
        disp_entry_i = mk(15, 1, 1, 1, 1, 1, 2);
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        disp_valid_i = 1'b0;
        disp_entry_i = '0;
        @(negedge clk);
        chk("reset_count", int'(count_o), 0);
        chk("reset_disp_ready", int'(disp_ready_o), 1);
        chk("reset_issue_valid", int'(issue_valid_o), 0);
        chk("reset_issue_entry_zero", int'(issue_entry_o == '0), 1);
        step();
        @(negedge clk);
        chk("reset_no_capture", int'(count_o), 0);

        foreach (vt[i]) begin
            bit now_rdy;
            int p1, p2;
            p1 = 10 + i;
            p2 = 30 + i;
            now_rdy = (!vt[i].u1 || vt[i].d1) && (!vt[i].u2 || vt[i].d2);
            step();
            disp(mk(vt[i].tag, vt[i].u1, vt[i].d1, p1, vt[i].u2, vt[i].d2, p2));
            if (now_rdy) push(vt[i].tag, cyc + 1);
            step();
            if (vt[i].wsrc != 0) begin
                wake(vt[i].wbus, (vt[i].wsrc == 1) ? p1 : p2, vt[i].wrdu);
                if (vt[i].issues && !now_rdy) push(vt[i].tag, cyc + 1);
            end
            repeat (3) step();
            @(negedge clk);
            chk($sformatf("vec%0d_count", i), int'(count_o), vt[i].exp_cnt);
            step();
            flush_i = 1'b1;
            step();
            @(negedge clk);
            chk($sformatf("vec%0d_flush_count", i), int'(count_o), 0);
        end

        // dispatch racing a writeback of its own source
        step();
        disp(mk(9, 0, 0, 0, 1, 0, 7));
        wake(0, 7, 1);
        push(9, cyc + 1);
        repeat (3) step();
        @(negedge clk);
        chk("race_count", int'(count_o), 0);

        // age order, slots in index order
        step();
        for (int t = 1; t <= 3; t++) begin
            disp(mk(t, 1, 0, 20, 0, 0, 0));
            step();
        end
        @(negedge clk);
        chk("age_count", int'(count_o), 3);
        step();
        wake(0, 20, 1);
        push(1, cyc + 1);
        push(2, cyc + 2);
        push(3, cyc + 3);
        repeat (4) step();
        @(negedge clk);
        chk("age_drain_count", int'(count_o), 0);

        // age order with a hole: tag 23 lands in slot 0, below tag 22
        step();
        disp(mk(21, 1, 1, 5, 0, 0, 0));
        push(21, cyc + 1);
        step();
        disp(mk(22, 1, 0, 20, 0, 0, 0));
        step();
        disp(mk(23, 1, 0, 20, 0, 0, 0));
        step();
        disp(mk(24, 1, 0, 20, 0, 0, 0));
        step();
        wake(1, 20, 1);
        push(22, cyc + 1);
        push(23, cyc + 2);
        push(24, cyc + 3);
        repeat (4) step();
        @(negedge clk);
        chk("hole_drain_count", int'(count_o), 0);

        // fill, overflow, then flush against ready entries
        step();
        for (int i = 0; i < DEPTH; i++) begin
            disp(mk(32 + i, 1, 0, 60, 0, 0, 0));
            step();
        end
        @(negedge clk);
        chk("full_count", int'(count_o), DEPTH);
        chk("full_disp_ready", int'(disp_ready_o), 0);
        step();
        disp(mk(50, 0, 0, 0, 0, 0, 0));
        step();
        @(negedge clk);
        chk("full_drop_count", int'(count_o), DEPTH);
        step();
        wake(0, 60, 1);
        step();
        flush_i = 1'b1;
        disp(mk(51, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("flush_issue_valid", int'(issue_valid_o), 0);
        step();
        @(negedge clk);
        chk("flush_count", int'(count_o), 0);
        repeat (4) step();
        @(negedge clk);
        chk("post_flush_count", int'(count_o), 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
